// File: rtl/counter_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | counter_arbiter: round-robin arbiter sequencing step/clear jobs onto a      |
// | shared modulo counter, checking it against an internal model. Rev 1.0      |
// +----------------------------------------------------------------------------+
module counter_arbiter #(
  parameter int STEP_W = 4,
  parameter int MOD    = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [1:0]        req_dir,
  input  logic [1:0]        req_clr,
  input  logic [STEP_W-1:0] req_steps0,
  input  logic [STEP_W-1:0] req_steps1,
  output logic              cnt_en,
  output logic              cnt_dir,
  output logic              cnt_clr,
  input  logic [3:0]        cnt_q,
  output logic              done_valid,
  input  logic              done_ready,
  output logic              done_id,
  output logic [3:0]        done_q,
  output logic              mismatch
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_RUN  = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [3:0] c_TOP = 4'(MOD - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_last_id;
  logic              r_id;
  logic              r_dir;
  logic [STEP_W-1:0] r_remaining;
  logic [3:0]        r_model;
  logic [3:0]        w_model_step;
  logic              w_accept;
  logic              w_gnt_id;
  logic              w_gnt_dir;
  logic              w_gnt_clr;
  logic [STEP_W-1:0] w_gnt_steps;

  // A tie goes to whichever requester was not granted last.
  always_comb begin
    w_gnt_id = 1'b0;
    case (req_valid)
      2'b10:   w_gnt_id = 1'b1;
      2'b11:   w_gnt_id = ~r_last_id;
      default: w_gnt_id = 1'b0;
    endcase
    w_gnt_dir   = req_dir[w_gnt_id];
    w_gnt_clr   = req_clr[w_gnt_id];
    w_gnt_steps = w_gnt_id ? req_steps1 : req_steps0;
    w_accept    = (r_state == S_IDLE) && (req_valid != 2'b00);
  end

  always_comb begin
    req_ready = 2'b00;
    if (w_accept && reset_n) begin
      req_ready = w_gnt_id ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    w_model_step = r_model;
    if (r_dir) begin
      w_model_step = (r_model >= c_TOP) ? 4'd0 : r_model + 4'd1;
    end else begin
      w_model_step = (r_model == 4'd0) ? c_TOP : r_model - 4'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    cnt_en      = 1'b0;
    cnt_clr     = 1'b0;
    done_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_gnt_clr) begin
            w_state_nxt = S_CLR;
          end else if (w_gnt_steps == '0) begin
            w_state_nxt = S_WAIT;
          end else begin
            w_state_nxt = S_RUN;
          end
        end
      end
      S_CLR: begin
        cnt_clr     = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_RUN: begin
        cnt_en = 1'b1;
        if (r_remaining == STEP_W'(1)) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done_valid = 1'b1;
        if (done_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign cnt_dir = r_dir;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // r_last_id resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_id   <= 1'b1;
      r_id        <= 1'b0;
      r_dir       <= 1'b0;
      r_remaining <= '0;
      r_model     <= 4'd0;
      done_id     <= 1'b0;
      done_q      <= 4'd0;
      mismatch    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_last_id   <= w_gnt_id;
        r_id        <= w_gnt_id;
        r_dir       <= w_gnt_dir;
        r_remaining <= w_gnt_steps;
      end
      if (r_state == S_RUN) begin
        r_remaining <= r_remaining - STEP_W'(1);
        r_model     <= w_model_step;
      end
      if (r_state == S_CLR) begin
        r_model <= 4'd0;
      end
      if (r_state == S_WAIT) begin
        done_q  <= cnt_q;
        done_id <= r_id;
        if (cnt_q != r_model) begin
          mismatch <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_counter_arbiter.sv
`default_nettype none
// Bench for counter_arbiter: models the shared counter and scoreboards
// every grant and completion against bench-computed expectations.
module tb_counter_arbiter;

  localparam int STEP_W = 4;
  localparam int MOD    = 10;

  typedef struct packed {
    logic       id;
    logic [3:0] q;
  } done_t;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0]        req_dir;
  logic [1:0]        req_clr;
  logic [STEP_W-1:0] req_steps0;
  logic [STEP_W-1:0] req_steps1;
  logic              cnt_en;
  logic              cnt_dir;
  logic              cnt_clr;
  logic [3:0]        cnt = 4'd0;
  logic              done_valid;
  logic              done_ready;
  logic              done_id;
  logic [3:0]        done_q;
  logic              mismatch;

  logic              frc;
  logic [3:0]        frc_val;
  logic [3:0]        ref_q;
  logic              g_exp;
  done_t             d_exp;
  logic              exp_grant_q[$];
  done_t             exp_done_q[$];
  int                n_checks = 0;
  int                n_fail   = 0;
  int                pops     = 0;
  int                exp_pops = 0;

  counter_arbiter #(.STEP_W(STEP_W), .MOD(MOD)) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_dir    (req_dir),
    .req_clr    (req_clr),
    .req_steps0 (req_steps0),
    .req_steps1 (req_steps1),
    .cnt_en     (cnt_en),
    .cnt_dir    (cnt_dir),
    .cnt_clr    (cnt_clr),
    .cnt_q      (cnt),
    .done_valid (done_valid),
    .done_ready (done_ready),
    .done_id    (done_id),
    .done_q     (done_q),
    .mismatch   (mismatch)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] step1(input logic [3:0] v, input logic d);
    if (d) return (v == 4'(MOD - 1)) ? 4'd0 : v + 4'd1;
    return (v == 4'd0) ? 4'(MOD - 1) : v - 4'd1;
  endfunction

  function automatic logic [3:0] step_n(input logic [3:0] v, input logic d, input int n);
    logic [3:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = step1(r, d);
    return r;
  endfunction

  // Shared counter owned by the environment; frc lets the bench corrupt it.
  always @(posedge clk) begin
    if (frc)          cnt <= frc_val;
    else if (cnt_clr) cnt <= 4'd0;
    else if (cnt_en)  cnt <= step1(cnt, cnt_dir);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (reset_n === 1'b1) begin
      if (req_ready != 2'b00) begin
        if (exp_grant_q.size() == 0) begin
          check_eq("grant_unexpected", 32'(req_ready), 32'd0);
        end else begin
          g_exp = exp_grant_q.pop_front();
          check_eq("grant_id", 32'(req_ready), g_exp ? 32'd2 : 32'd1);
        end
      end
      if (done_valid && done_ready) begin
        if (exp_done_q.size() == 0) begin
          check_eq("done_unexpected", 32'(done_valid), 32'd0);
        end else begin
          d_exp = exp_done_q.pop_front();
          check_eq("done_id", 32'(done_id), 32'(d_exp.id));
          check_eq("done_q", 32'(done_q), 32'(d_exp.q));
        end
        pops++;
      end
    end
  end

  task automatic wait_pops();
    for (int c = 0; c < 40 && pops < exp_pops; c++) begin
      @(negedge clk);
      #3;
    end
    check_eq("drain", pops, exp_pops);
  endtask

  task automatic check_zero_outs(input string tag);
    check_eq({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check_eq({tag, "_cnt_en"}, 32'(cnt_en), 32'd0);
    check_eq({tag, "_cnt_dir"}, 32'(cnt_dir), 32'd0);
    check_eq({tag, "_cnt_clr"}, 32'(cnt_clr), 32'd0);
    check_eq({tag, "_done_valid"}, 32'(done_valid), 32'd0);
    check_eq({tag, "_done_id"}, 32'(done_id), 32'd0);
    check_eq({tag, "_done_q"}, 32'(done_q), 32'd0);
    check_eq({tag, "_mismatch"}, 32'(mismatch), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; req_valid = 2'b00; done_ready = 1'b1; frc = 1'b1; frc_val = 4'd0;
    @(negedge clk);
    frc = 1'b0;
    @(negedge clk);
    #2;
    check_zero_outs("rst");
    ref_q = 4'd0;
  endtask

  task automatic set_steps(input logic id, input logic [STEP_W-1:0] s);
    if (id) req_steps1 = s;
    else    req_steps0 = s;
  endtask

  task automatic run_job(input logic id, input logic dir, input logic clr,
                         input int steps, input int hold);
    logic [3:0] exp_q;
    logic [3:0] pq;
    logic       oth;
    logic       dir_ok;
    int         en_cnt;
    int         clr_cnt;
    int         lat;
    en_cnt = 0; clr_cnt = 0; lat = -1; dir_ok = 1'b1; oth = ~id;
    exp_q = clr ? 4'd0 : step_n(ref_q, dir, steps);
    ref_q = exp_q;
    exp_grant_q.push_back(id);
    exp_done_q.push_back(done_t'{id: id, q: exp_q});
    exp_pops++;
    @(negedge clk);
    done_ready = (hold == 0);
    req_valid[id] = 1'b1; req_dir[id] = dir; req_clr[id] = clr;
    set_steps(id, STEP_W'(steps));
    #2;
    check_eq("accept_ready", 32'(req_ready), id ? 32'd2 : 32'd1);
    @(negedge clk);
    // Scramble the request fields: the job must run on the accepted values.
    req_valid[id] = 1'b0; req_dir[id] = ~dir; req_clr[id] = ~clr;
    set_steps(id, ~STEP_W'(steps));
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      if (c > 1) @(negedge clk);
      #2;
      if (cnt_en) begin
        en_cnt++;
        if (cnt_dir !== dir) dir_ok = 1'b0;
      end
      if (cnt_clr) clr_cnt++;
      if (done_valid) lat = c;
    end
    check_eq("done_seen", 32'(lat >= 0), 32'd1);
    if (lat >= 0 && !clr) check_eq("latency", lat, steps + 2);
    check_eq("en_cycles", en_cnt, clr ? 0 : steps);
    check_eq("clr_pulses", clr_cnt, clr ? 1 : 0);
    check_eq("run_dir", 32'(dir_ok), 32'd1);
    check_eq("dir_hold", 32'(cnt_dir), 32'(dir));
    if (hold > 0) begin
      for (int h = 1; h <= hold; h++) begin
        @(negedge clk);
        if (h == 1) begin
          pq = step1(ref_q, 1'b1);
          ref_q = pq;
          exp_grant_q.push_back(oth);
          exp_done_q.push_back(done_t'{id: oth, q: pq});
          exp_pops++;
          req_valid[oth] = 1'b1; req_dir[oth] = 1'b1; req_clr[oth] = 1'b0;
          set_steps(oth, STEP_W'(1));
        end
        #2;
        check_eq("hold_valid", 32'(done_valid), 32'd1);
        check_eq("hold_q", 32'(done_q), 32'(exp_q));
        check_eq("hold_id", 32'(done_id), 32'(id));
        check_eq("hold_ready", 32'(req_ready), 32'd0);
      end
      @(negedge clk);
      done_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      req_valid[oth] = 1'b0;
    end
    wait_pops();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   g;
    int   en;
    logic seen;
    reset_n = 1'b0; req_valid = 2'b00; req_dir = 2'b00; req_clr = 2'b00;
    req_steps0 = '0; req_steps1 = '0; done_ready = 1'b1; frc = 1'b0; frc_val = 4'd0;
    ref_q = 4'd0;

    // Both requesters valid from the first cycle out of reset: grants alternate from 0.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      ref_q = step1(ref_q, 1'b1);
      exp_grant_q.push_back(1'(i % 2));
      exp_done_q.push_back(done_t'{id: 1'(i % 2), q: ref_q});
      exp_pops++;
    end
    @(negedge clk);
    reset_n = 1'b1; req_valid = 2'b11; req_dir = 2'b11; req_clr = 2'b00;
    req_steps0 = STEP_W'(1); req_steps1 = STEP_W'(1);
    g = 0;
    for (int c = 0; c < 60 && g < 4; c++) begin
      if (c > 0) @(negedge clk);
      #2;
      if (req_ready != 2'b00) g++;
    end
    check_eq("alt_grants", g, 4);
    @(negedge clk);
    req_valid = 2'b00;
    wait_pops();

    // Basic up-count, wraps in both directions, zero-step job.
    do_reset();
    @(negedge clk);
    reset_n = 1'b1;
    run_job(1'b0, 1'b1, 1'b0, 3, 0);
    run_job(1'b0, 1'b1, 1'b0, 5, 0);
    run_job(1'b1, 1'b1, 1'b0, 4, 0);
    run_job(1'b1, 1'b0, 1'b0, 3, 0);
    run_job(1'b1, 1'b1, 1'b0, 0, 0);
    check_eq("mismatch_clean", 32'(mismatch), 32'd0);

    // Clear job, then a completion held off with another request pending.
    run_job(1'b0, 1'b0, 1'b1, 7, 0);
    run_job(1'b1, 1'b0, 1'b0, 2, 5);
    check_eq("mismatch_clean2", 32'(mismatch), 32'd0);

    // Reset in the middle of a long job, then a corrupted counter.
    exp_grant_q.push_back(1'b0);
    @(negedge clk);
    req_valid = 2'b01; req_dir = 2'b01; req_clr = 2'b00; req_steps0 = STEP_W'(9);
    @(negedge clk);
    req_valid = 2'b00;
    en = 0;
    for (int c = 0; c < 30 && en < 4; c++) begin
      if (c > 0) @(negedge clk);
      #2;
      if (cnt_en) en++;
    end
    check_eq("abort_en_seen", en, 4);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_zero_outs("abort");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      #2;
      if (done_valid) seen = 1'b1;
    end
    check_eq("no_replay", 32'(seen), 32'd0);
    @(negedge clk);
    frc = 1'b1; frc_val = 4'd5;
    @(negedge clk);
    frc = 1'b0;
    ref_q = 4'd5;
    run_job(1'b0, 1'b1, 1'b0, 1, 0);
    check_eq("mismatch_set", 32'(mismatch), 32'd1);

    check_eq("grant_q_empty", exp_grant_q.size(), 0);
    check_eq("done_q_empty", exp_done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
